// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR tap-RAM arbiter.
package fir_pkg;

    localparam int unsigned TAP_BASE = 32'h80;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CW,
        OWN_CR,
        OWN_EN
    } owner_e;

    // Config byte address hits a word-aligned tap slot.
    function automatic logic tap_in_range(input logic [31:0] addr, input int unsigned tape_num);
        return (addr >= TAP_BASE)
            && (addr <= TAP_BASE + 32'd4 * tape_num - 32'd1)
            && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fir_tap_arbiter_if.sv
// Requester-side handshakes (config write, config read, engine fetch) of the tap arbiter.
interface fir_tap_arbiter_if #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32
);
    logic                   cw_req;
    logic [pADDR_WIDTH-1:0] cw_addr;
    logic [pDATA_WIDTH-1:0] cw_data;
    logic                   cw_gnt;
    logic                   cw_err;

    logic                   cr_req;
    logic [pADDR_WIDTH-1:0] cr_addr;
    logic                   cr_gnt;
    logic                   cr_rvalid;
    logic [pDATA_WIDTH-1:0] cr_rdata;
    logic                   cr_err;

    logic                   en_req;
    logic [pADDR_WIDTH-1:0] en_idx;
    logic                   en_gnt;
    logic                   en_rvalid;
    logic [pDATA_WIDTH-1:0] en_rdata;

    modport master (
        output cw_req, cw_addr, cw_data, cr_req, cr_addr, en_req, en_idx,
        input  cw_gnt, cw_err, cr_gnt, cr_rvalid, cr_rdata, cr_err,
               en_gnt, en_rvalid, en_rdata
    );

    modport slave (
        input  cw_req, cw_addr, cw_data, cr_req, cr_addr, en_req, en_idx,
        output cw_gnt, cw_err, cr_gnt, cr_rvalid, cr_rdata, cr_err,
               en_gnt, en_rvalid, en_rdata
    );
endinterface

// File: rtl/fir_tap_addr_check.sv
// Config address decode: legal tap slot check and byte offset into the tap RAM.
module fir_tap_addr_check
    import fir_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned Tape_Num    = 11
) (
    input  logic [pADDR_WIDTH-1:0] addr,
    output logic                   in_range,
    output logic [pADDR_WIDTH-1:0] offset
);

    assign in_range = tap_in_range(32'(addr), Tape_Num);
    assign offset   = in_range ? (addr - pADDR_WIDTH'(TAP_BASE)) : '0;

endmodule

// File: rtl/fir_tap_arbiter.sv
// Single-port tap RAM arbiter: config write/read vs. FIR engine fetch, with write
// protection and bounded config-read latency while the engine is running.
module fir_tap_arbiter
    import fir_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned Tape_Num    = 11,
    parameter int unsigned pMAX_WAIT   = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   engine_busy,
    fir_tap_arbiter_if.slave       bus,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do
);

    localparam int unsigned CNT_W = $clog2(pMAX_WAIT + 1);

    logic                   cw_ok;
    logic                   cr_ok;
    logic                   en_ok;
    logic [pADDR_WIDTH-1:0] cw_off;
    logic [pADDR_WIDTH-1:0] cr_off;

    fir_tap_addr_check #(.pADDR_WIDTH(pADDR_WIDTH), .Tape_Num(Tape_Num)) u_cw_chk (
        .addr     (bus.cw_addr),
        .in_range (cw_ok),
        .offset   (cw_off)
    );

    fir_tap_addr_check #(.pADDR_WIDTH(pADDR_WIDTH), .Tape_Num(Tape_Num)) u_cr_chk (
        .addr     (bus.cr_addr),
        .in_range (cr_ok),
        .offset   (cr_off)
    );

    assign en_ok = (32'(bus.en_idx) < Tape_Num);

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    owner_e                 owner_q, owner_d;
    logic                   nodata_q, nodata_d;
    logic [pDATA_WIDTH-1:0] cr_hold_q;
    logic [pDATA_WIDTH-1:0] en_hold_q;

    logic                   starved;
    logic                   pick_cr;
    logic                   pick_en;
    logic                   cw_gnt_a, cw_err_a, cr_gnt_a, en_gnt_a;
    logic                   ram_en;
    logic [3:0]             ram_we;
    logic [pDATA_WIDTH-1:0] ram_di;
    logic [pADDR_WIDTH-1:0] ram_a;

    assign starved = (cnt_q == CNT_W'(pMAX_WAIT));

    // Arbitration and BRAM drive for the current cycle.
    always_comb begin
        cw_gnt_a = 1'b0;
        cw_err_a = 1'b0;
        cr_gnt_a = 1'b0;
        en_gnt_a = 1'b0;
        pick_cr  = 1'b0;
        pick_en  = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 4'h0;
        ram_di   = '0;
        ram_a    = '0;
        owner_d  = OWN_NONE;
        nodata_d = 1'b0;
        cnt_d    = cnt_q;

        if (!engine_busy) begin
            cnt_d = '0;
            if (bus.cw_req) begin
                cw_gnt_a = 1'b1;
                cw_err_a = !cw_ok;
                if (cw_ok) begin
                    ram_en = 1'b1;
                    ram_we = 4'hF;
                    ram_di = bus.cw_data;
                    ram_a  = cw_off;
                end
            end else if (bus.cr_req) begin
                pick_cr = 1'b1;
            end else if (bus.en_req) begin
                pick_en = 1'b1;
            end
        end else begin
            // Writes are refused without touching the RAM, so the slot stays free.
            if (bus.cw_req) begin
                cw_gnt_a = 1'b1;
                cw_err_a = 1'b1;
            end
            if (bus.cr_req && (!bus.en_req || starved)) begin
                pick_cr = 1'b1;
            end else if (bus.en_req) begin
                pick_en = 1'b1;
                if (bus.cr_req) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        if (pick_cr) begin
            cr_gnt_a = 1'b1;
            owner_d  = OWN_CR;
            nodata_d = !cr_ok;
            cnt_d    = '0;
            if (cr_ok) begin
                ram_en = 1'b1;
                ram_a  = cr_off;
            end
        end else if (pick_en) begin
            en_gnt_a = 1'b1;
            owner_d  = OWN_EN;
            nodata_d = !en_ok;
            if (en_ok) begin
                ram_en = 1'b1;
                ram_a  = bus.en_idx << 2;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            cnt_q     <= '0;
            owner_q   <= OWN_NONE;
            nodata_q  <= 1'b0;
            cr_hold_q <= '0;
            en_hold_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            nodata_q <= nodata_d;
            if (bus.cr_rvalid) begin
                cr_hold_q <= bus.cr_rdata;
            end
            if (bus.en_rvalid) begin
                en_hold_q <= bus.en_rdata;
            end
        end
    end

    logic [pDATA_WIDTH-1:0] ret_data;

    // Read return follows the owner tag registered at grant time.
    assign ret_data      = nodata_q ? '0 : tap_Do;
    assign bus.cr_rvalid = (owner_q == OWN_CR);
    assign bus.cr_err    = bus.cr_rvalid & nodata_q;
    assign bus.cr_rdata  = bus.cr_rvalid ? ret_data : cr_hold_q;
    assign bus.en_rvalid = (owner_q == OWN_EN);
    assign bus.en_rdata  = bus.en_rvalid ? ret_data : en_hold_q;

    // Grants and RAM strobes are held quiet while reset is asserted.
    assign bus.cw_gnt = axis_rst_n & cw_gnt_a;
    assign bus.cw_err = axis_rst_n & cw_err_a;
    assign bus.cr_gnt = axis_rst_n & cr_gnt_a;
    assign bus.en_gnt = axis_rst_n & en_gnt_a;
    assign tap_EN     = axis_rst_n & ram_en;
    assign tap_WE     = axis_rst_n ? ram_we : 4'h0;
    assign tap_Di     = axis_rst_n ? ram_di : '0;
    assign tap_A      = axis_rst_n ? ram_a  : '0;

endmodule

// File: tb/tb_fir_tap_arbiter.sv
// Randomised + directed bench for fir_tap_arbiter against a transaction-level model.
module tb_fir_tap_arbiter;

    localparam int unsigned AW   = 12;
    localparam int unsigned DW   = 32;
    localparam int unsigned TAPS = 11;
    localparam int unsigned MAXW = 4;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n;
    logic          engine_busy;
    logic [3:0]    tap_WE;
    logic          tap_EN;
    logic [DW-1:0] tap_Di;
    logic [AW-1:0] tap_A;
    logic [DW-1:0] tap_Do;

    fir_tap_arbiter_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

    fir_tap_arbiter #(
        .pADDR_WIDTH (AW),
        .pDATA_WIDTH (DW),
        .Tape_Num    (TAPS),
        .pMAX_WAIT   (MAXW)
    ) dut (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .engine_busy (engine_busy),
        .bus         (bus),
        .tap_WE      (tap_WE),
        .tap_EN      (tap_EN),
        .tap_Di      (tap_Di),
        .tap_A       (tap_A),
        .tap_Do      (tap_Do)
    );

    always #5 axis_clk = ~axis_clk;

    // Single-port BRAM with one-cycle read latency.
    logic [DW-1:0] ram [0:1023];
    initial for (int i = 0; i < 1024; i++) ram[i] = '0;
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            for (int b = 0; b < 4; b++)
                if (tap_WE[b]) ram[tap_A >> 2][8*b +: 8] <= tap_Di[8*b +: 8];
            tap_Do <= ram[tap_A >> 2];
        end
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_mem [TAPS];
    int          wait_n;
    logic        pend_cr, pend_cr_err, pend_en;
    logic [31:0] pend_cr_data, pend_en_data, cr_hold, en_hold;
    logic        obs_cr_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit inr(input logic [AW-1:0] a);
        int v = int'(a);
        return (v >= 128) && (v <= 128 + 4 * int'(TAPS) - 1) && (v % 4 == 0);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 9))
            0: return AW'(12'hAC);
            1: return AW'(12'h82);
            2: return AW'(12'h7C);
            3: return AW'($urandom);
            default: return AW'(128 + 4 * $urandom_range(0, TAPS - 1));
        endcase
    endfunction

    // One clock of traffic: predict grants/RAM drive, check them, then check the return.
    task automatic run_cycle();
        bit          g_cw, g_cr, g_en, cw_bad;
        bit          e_en;
        logic [3:0]  e_we;
        logic [31:0] e_a, e_di;
        g_cw = 0; g_cr = 0; g_en = 0; cw_bad = 0;
        if (!engine_busy) begin
            if (bus.cw_req)      begin g_cw = 1; cw_bad = !inr(bus.cw_addr); end
            else if (bus.cr_req) g_cr = 1;
            else if (bus.en_req) g_en = 1;
        end else begin
            if (bus.cw_req) begin g_cw = 1; cw_bad = 1; end
            if (bus.cr_req && (!bus.en_req || wait_n == int'(MAXW))) g_cr = 1;
            else if (bus.en_req) g_en = 1;
        end
        e_en = 0; e_we = 0; e_a = 0; e_di = 0;
        if (g_cw && !cw_bad) begin
            e_en = 1; e_we = 4'hF; e_a = 32'(bus.cw_addr) - 128; e_di = bus.cw_data;
        end else if (g_cr && inr(bus.cr_addr)) begin
            e_en = 1; e_a = 32'(bus.cr_addr) - 128;
        end else if (g_en && int'(bus.en_idx) < int'(TAPS)) begin
            e_en = 1; e_a = 32'(bus.en_idx) * 4;
        end
        #2;
        obs_cr_gnt = bus.cr_gnt;
        chk("cw_gnt", 32'(bus.cw_gnt), 32'(g_cw));
        chk("cw_err", 32'(bus.cw_err), 32'(g_cw & cw_bad));
        chk("cr_gnt", 32'(bus.cr_gnt), 32'(g_cr));
        chk("en_gnt", 32'(bus.en_gnt), 32'(g_en));
        chk("tap_EN", 32'(tap_EN), 32'(e_en));
        chk("tap_WE", 32'(tap_WE), 32'(e_we));
        chk("tap_A",  32'(tap_A), e_a);
        chk("tap_Di", tap_Di, e_di);
        if (g_cw && !cw_bad) ref_mem[(int'(bus.cw_addr) - 128) / 4] = bus.cw_data;
        pend_cr      = g_cr;
        pend_cr_err  = g_cr && !inr(bus.cr_addr);
        pend_cr_data = (g_cr && inr(bus.cr_addr)) ? ref_mem[(int'(bus.cr_addr) - 128) / 4] : 32'h0;
        pend_en      = g_en;
        pend_en_data = (g_en && int'(bus.en_idx) < int'(TAPS)) ? ref_mem[int'(bus.en_idx)] : 32'h0;
        if (!engine_busy || g_cr) wait_n = 0;
        else if (bus.cr_req && g_en) wait_n++;
        @(posedge axis_clk); #1;
        if (pend_cr) cr_hold = pend_cr_data;
        if (pend_en) en_hold = pend_en_data;
        chk("cr_rvalid", 32'(bus.cr_rvalid), 32'(pend_cr));
        chk("cr_err",    32'(bus.cr_err), 32'(pend_cr_err));
        chk("cr_rdata",  bus.cr_rdata, cr_hold);
        chk("en_rvalid", 32'(bus.en_rvalid), 32'(pend_en));
        chk("en_rdata",  bus.en_rdata, en_hold);
        if (g_cw) bus.cw_req = 1'b0;
        if (g_cr) bus.cr_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnts"}, 32'({bus.cw_gnt, bus.cw_err, bus.cr_gnt, bus.en_gnt}), 32'h0);
        chk({tag, "_rv"}, 32'({bus.cr_rvalid, bus.cr_err, bus.en_rvalid}), 32'h0);
        chk({tag, "_rdata"}, bus.cr_rdata | bus.en_rdata, 32'h0);
        chk({tag, "_ram"}, 32'({tap_EN, tap_WE}) | 32'(tap_A) | tap_Di, 32'h0);
    endtask

    task automatic model_reset();
        wait_n = 0; cr_hold = 0; en_hold = 0; pend_cr = 0; pend_en = 0;
    endtask

    initial begin
        int          first;
        logic [31:0] old;
        model_reset();
        for (int i = 0; i < int'(TAPS); i++) ref_mem[i] = '0;

        // Reset with every requester active: nothing may leak out.
        axis_rst_n  = 1'b0;
        engine_busy = 1'b0;
        bus.cw_req = 1'b1; bus.cw_addr = AW'(12'h84); bus.cw_data = 32'h1;
        bus.cr_req = 1'b1; bus.cr_addr = AW'(12'h84);
        bus.en_req = 1'b1; bus.en_idx  = AW'(1);
        #2;
        chk_all_zero("reset");
        @(posedge axis_clk); @(posedge axis_clk); #1;
        chk_all_zero("reset_clk");
        bus.cw_req = 1'b0; bus.cr_req = 1'b0; bus.en_req = 1'b0;
        axis_rst_n = 1'b1;

        // Load every tap with random data.
        for (int i = 0; i < int'(TAPS); i++) begin
            bus.cw_req = 1'b1; bus.cw_addr = AW'(128 + 4 * i); bus.cw_data = $urandom;
            run_cycle();
        end

        // Write 0x84=5 then read it back.
        bus.cw_req = 1'b1; bus.cw_addr = AW'(12'h84); bus.cw_data = 32'd5;
        run_cycle();
        bus.cr_req = 1'b1; bus.cr_addr = AW'(12'h84);
        run_cycle();
        chk("rd84", bus.cr_rdata, 32'd5);

        // Same-cycle write and read to 0x88: read observes the new value.
        bus.cw_req = 1'b1; bus.cw_addr = AW'(12'h88); bus.cw_data = 32'd2;
        run_cycle();
        bus.cw_req = 1'b1; bus.cw_data = 32'd9;
        bus.cr_req = 1'b1; bus.cr_addr = AW'(12'h88);
        run_cycle();
        chk("same_cyc_cr_wait", 32'(obs_cr_gnt), 32'h0);
        run_cycle();
        chk("same_cyc_cr_gnt", 32'(obs_cr_gnt), 32'h1);
        chk("rd88", bus.cr_rdata, 32'd9);

        // Write protection while busy.
        old = ref_mem[0];
        engine_busy = 1'b1;
        bus.cw_req = 1'b1; bus.cw_addr = AW'(12'h80); bus.cw_data = 32'd7;
        run_cycle();
        engine_busy = 1'b0;
        bus.cr_req = 1'b1; bus.cr_addr = AW'(12'h80);
        run_cycle();
        chk("protect_rd80", bus.cr_rdata, old);

        // Starvation bound: engine wins MAXW cycles, then the config read.
        run_cycle();
        engine_busy = 1'b1;
        bus.en_req = 1'b1; bus.en_idx = AW'(2);
        bus.cr_req = 1'b1; bus.cr_addr = AW'(12'h90);
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            run_cycle();
            if (obs_cr_gnt && first == 0) first = i;
        end
        chk("starve_cycle", 32'(first), 32'(MAXW + 1));
        bus.en_req = 1'b0; engine_busy = 1'b0;

        // Out-of-range reads.
        bus.cr_req = 1'b1; bus.cr_addr = AW'(12'hAC);
        run_cycle();
        chk("oor_ac_err", 32'({bus.cr_rvalid, bus.cr_err}), 32'h3);
        bus.cr_req = 1'b1; bus.cr_addr = AW'(12'h82);
        run_cycle();
        chk("oor_82_err", 32'({bus.cr_rvalid, bus.cr_err}), 32'h3);
        chk("oor_82_data", bus.cr_rdata, 32'h0);

        // Randomised mixed traffic.
        for (int n = 0; n < 400; n++) begin
            if (!bus.cw_req && $urandom_range(0, 3) == 0) begin
                bus.cw_req = 1'b1; bus.cw_addr = rand_addr(); bus.cw_data = $urandom;
            end
            if (!bus.cr_req && $urandom_range(0, 2) == 0) begin
                bus.cr_req = 1'b1; bus.cr_addr = rand_addr();
            end
            bus.en_req = 1'($urandom_range(0, 1));
            bus.en_idx = AW'($urandom_range(0, TAPS + 2));
            if ($urandom_range(0, 15) == 0) engine_busy = ~engine_busy;
            run_cycle();
        end

        // Reset right after an engine grant: the return must never appear.
        bus.cw_req = 1'b0; bus.cr_req = 1'b0; bus.en_req = 1'b0; engine_busy = 1'b0;
        run_cycle();
        engine_busy = 1'b1; bus.en_req = 1'b1; bus.en_idx = AW'(3);
        #2;
        chk("rst_en_gnt", 32'(bus.en_gnt), 32'h1);
        #1 axis_rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge axis_clk); #1;
        chk("midrst_en_rvalid", 32'(bus.en_rvalid), 32'h0);
        @(posedge axis_clk); #1;
        bus.en_req = 1'b0; engine_busy = 1'b0;
        axis_rst_n = 1'b1;
        model_reset();
        run_cycle();
        run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
